// File: rtl/irsx_register_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// irsx_register_arbiter_pkg
// Shared definitions for the register-write arbiter:
//   - arb_state_t      : arbiter FSM state encoding
//   - ASIC_ADDR_WIDTH  : width of the register interface address (8)
//   - ASIC_DATA_WIDTH  : width of the register interface data (12)
//   - index_width()    : bits needed to hold a requester index
// ---------------------------------------------------------------------------
package irsx_register_arbiter_pkg;

  localparam int ASIC_ADDR_WIDTH = 8;
  localparam int ASIC_DATA_WIDTH = 12;

  // ST_VERIFY is only ever entered when readback verification is built in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  // A single requester still needs a one-bit index so the vectors stay legal.
  function automatic int index_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/irsx_register_arbiter_round_robin_picker.sv
// ---------------------------------------------------------------------------
// irsx_round_robin_picker
// Combinational round-robin selector. The search starts one past the last
// granted index and wraps modulo NUMBER_OF_REQUESTERS.
// Ports:
//   request    : in  [NUMBER_OF_REQUESTERS-1:0] requests eligible this cycle
//   last_grant : in  [INDEX_WIDTH-1:0]          most recently granted index
//   valid      : out                            some request was found
//   index      : out [INDEX_WIDTH-1:0]          winning requester
// ---------------------------------------------------------------------------
module irsx_round_robin_picker #(
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int INDEX_WIDTH          = 2
) (
  input  logic [NUMBER_OF_REQUESTERS-1:0] request,
  input  logic [INDEX_WIDTH-1:0]          last_grant,
  output logic                            valid,
  output logic [INDEX_WIDTH-1:0]          index
);

  logic [INDEX_WIDTH-1:0] candidate;

  // Walk offsets 1..N from last_grant; offset N lands back on last_grant, so
  // a lone requester that was just served can still win again.
  always_comb begin
    valid     = 1'b0;
    index     = '0;
    candidate = '0;
    for (int offset = 1; offset <= NUMBER_OF_REQUESTERS; offset++) begin
      candidate = INDEX_WIDTH'((int'(last_grant) + offset) % NUMBER_OF_REQUESTERS);
      if (!valid && request[candidate]) begin
        valid = 1'b1;
        index = candidate;
      end
    end
  end

endmodule

// File: rtl/irsx_register_arbiter.sv
// ---------------------------------------------------------------------------
// irsx_register_arbiter
// Arbitrates register-write requests from several requesters onto a single
// register interface. Each granted request is written once and, optionally,
// verified by reading the register back until it matches or times out.
//
// Build option: define IRSX_ARBITER_VERIFY_EN to include the VERIFY state and
// the timeout path. Without it, error and number_of_timeouts are constant 0
// and readback_data_out is ignored.
//
// Ports:
//   clock              : in   single clock
//   reset              : in   synchronous, active-high reset
//   req                : in   [N-1:0]    per-requester write request
//   req_address        : in   [8N-1:0]   requester i uses [8i+7:8i]
//   req_data           : in   [12N-1:0]  requester i uses [12i+11:12i]
//   ack                : out  [N-1:0]    one-cycle completion pulse
//   error              : out  [N-1:0]    one-cycle verify-timeout pulse
//   address            : out  [7:0]      register interface address
//   intended_data_in   : out  [11:0]     register interface write data
//   write_enable       : out             register interface write strobe
//   readback_data_out  : in   [11:0]     register interface readback
//   busy               : out             arbiter not in IDLE
//   number_of_timeouts : out  [31:0]     saturating count of verify timeouts
// ---------------------------------------------------------------------------
module irsx_register_arbiter
  import irsx_register_arbiter_pkg::*;
#(
  parameter int NUMBER_OF_REQUESTERS  = 4,
  parameter int VERIFY_TIMEOUT_CYCLES = 4096,
  parameter int VERIFY_LATENCY        = 3
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [NUMBER_OF_REQUESTERS-1:0]                req,
  input  logic [ASIC_ADDR_WIDTH*NUMBER_OF_REQUESTERS-1:0] req_address,
  input  logic [ASIC_DATA_WIDTH*NUMBER_OF_REQUESTERS-1:0] req_data,
  output logic [NUMBER_OF_REQUESTERS-1:0]                ack,
  output logic [NUMBER_OF_REQUESTERS-1:0]                error,
  output logic [ASIC_ADDR_WIDTH-1:0]                     address,
  output logic [ASIC_DATA_WIDTH-1:0]                     intended_data_in,
  output logic                                          write_enable,
  input  logic [ASIC_DATA_WIDTH-1:0]                     readback_data_out,
  output logic                                          busy,
  output logic [31:0]                                   number_of_timeouts
);

  localparam int INDEX_WIDTH = index_width(NUMBER_OF_REQUESTERS);

  arb_state_t state;
  arb_state_t next_state;

  logic [INDEX_WIDTH-1:0]          grant_index;
  logic [INDEX_WIDTH-1:0]          last_grant;
  logic [INDEX_WIDTH-1:0]          pick_index;
  logic                            pick_valid;
  logic                            mask_active;
  logic                            finishing;
  logic [NUMBER_OF_REQUESTERS-1:0] grant_onehot;
  logic [NUMBER_OF_REQUESTERS-1:0] masked_req;
  logic [ASIC_ADDR_WIDTH-1:0]      pick_address;
  logic [ASIC_DATA_WIDTH-1:0]      pick_data;

  assign grant_onehot = NUMBER_OF_REQUESTERS'(1) << grant_index;

  // The requester that was just served sits out the first IDLE cycle, so a
  // requester re-raising req immediately cannot starve the others.
  assign masked_req = req & ~(mask_active ? grant_onehot : '0);

  assign pick_address = req_address[ASIC_ADDR_WIDTH*pick_index +: ASIC_ADDR_WIDTH];
  assign pick_data    = req_data[ASIC_DATA_WIDTH*pick_index +: ASIC_DATA_WIDTH];

  irsx_round_robin_picker #(
    .NUMBER_OF_REQUESTERS (NUMBER_OF_REQUESTERS),
    .INDEX_WIDTH          (INDEX_WIDTH)
  ) u_picker (
    .request    (masked_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_index)
  );

`ifdef IRSX_ARBITER_VERIFY_EN
  logic [31:0] verify_count;
  logic        verify_match;
  logic        verify_timeout;

  // Readback is ignored until the interface has had VERIFY_LATENCY cycles to
  // settle; a match on the final allowed cycle still wins over the timeout.
  assign verify_match   = (verify_count >= 32'(VERIFY_LATENCY)) &&
                          (readback_data_out == intended_data_in);
  assign verify_timeout = !verify_match &&
                          (verify_count >= 32'(VERIFY_TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      verify_count       <= '0;
      number_of_timeouts <= '0;
    end else begin
      if (state == ST_VERIFY) begin
        verify_count <= verify_count + 32'd1;
      end else begin
        verify_count <= '0;
      end
      if ((state == ST_VERIFY) && verify_timeout && (number_of_timeouts != '1)) begin
        number_of_timeouts <= number_of_timeouts + 32'd1;
      end
    end
  end
`else
  logic unused_verify;
  assign unused_verify = ^{readback_data_out, 32'(VERIFY_LATENCY), 32'(VERIFY_TIMEOUT_CYCLES)};
  assign number_of_timeouts = '0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode. ack/error come straight from the state so
  // only one of them, for the granted requester, can ever be high.
  always_comb begin
    next_state   = state;
    write_enable = 1'b0;
    busy         = (state != ST_IDLE);
    ack          = '0;
    error        = '0;
    finishing    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        write_enable = 1'b1;
`ifdef IRSX_ARBITER_VERIFY_EN
        next_state = ST_VERIFY;
`else
        next_state = ST_DONE;
`endif
      end
      ST_VERIFY: begin
`ifdef IRSX_ARBITER_VERIFY_EN
        if (verify_match) begin
          next_state = ST_DONE;
        end else if (verify_timeout) begin
          next_state = ST_IDLE;
          error      = grant_onehot;
          finishing  = 1'b1;
        end
`else
        next_state = ST_IDLE;
`endif
      end
      ST_DONE: begin
        next_state = ST_IDLE;
        ack        = grant_onehot;
        finishing  = 1'b1;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping and the register interface drive. The latched address
  // and data persist through IDLE until the next grant overwrites them.
  always_ff @(posedge clock) begin
    if (reset) begin
      address          <= '0;
      intended_data_in <= '0;
      grant_index      <= '0;
      last_grant       <= INDEX_WIDTH'(NUMBER_OF_REQUESTERS - 1);
      mask_active      <= 1'b0;
    end else begin
      mask_active <= finishing;
      if ((state == ST_IDLE) && pick_valid) begin
        grant_index      <= pick_index;
        last_grant       <= pick_index;
        address          <= pick_address;
        intended_data_in <= pick_data;
      end
    end
  end

endmodule

// File: tb/tb_irsx_register_arbiter.sv
// ---------------------------------------------------------------------------
// tb_irsx_register_arbiter
// Self-checking bench for irsx_register_arbiter. Directed steps cover reset,
// a single write, round-robin fairness and reset during WRITE; the default
// build adds a randomized run against a transaction-level model, and builds
// with IRSX_ARBITER_VERIFY_EN add readback-match, drop-mid-verify and
// timeout scenarios.
// ---------------------------------------------------------------------------
module tb_irsx_register_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 4096;
  localparam int LAT     = 3;
  // Cycles a transaction occupies the arbiter without verify: WRITE, DONE,
  // then the IDLE cycle in which the next request can be sampled.
  localparam int TXN_CYCLES = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_address;
  logic [47:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  error;
  logic [7:0]  address;
  logic [11:0] intended_data_in;
  logic        write_enable;
  logic [11:0] readback_data_out;
  logic        busy;
  logic [31:0] number_of_timeouts;

  int compared   = 0;
  int mismatched = 0;

  // Register-interface model: stores writes, returns the value at the
  // address seen a few cycles ago, or all zeros when zero_mode is set.
  logic [11:0] reg_mem [256];
  logic [7:0]  addr_pipe [3];
  bit          zero_mode = 1'b0;

  // Random-run model state.
  bit [3:0]    pending;
  int          s_cycle;
  int          winner;
  int          prev;
  int          last_rr;
  int          next_free;
  int          cand;
  bit          have_prev;
  bit          found;
  logic [3:0]  elig;
  logic [7:0]  exp_addr;
  logic [11:0] exp_data;
  logic [3:0]  exp_ack;
  logic [3:0]  got_ack;
  logic [3:0]  got_err;
  int          cycles;
  int          extra;

  irsx_register_arbiter #(
    .NUMBER_OF_REQUESTERS  (NREQ),
    .VERIFY_TIMEOUT_CYCLES (TIMEOUT),
    .VERIFY_LATENCY        (LAT)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .req                (req),
    .req_address        (req_address),
    .req_data           (req_data),
    .ack                (ack),
    .error              (error),
    .address            (address),
    .intended_data_in   (intended_data_in),
    .write_enable       (write_enable),
    .readback_data_out  (readback_data_out),
    .busy               (busy),
    .number_of_timeouts (number_of_timeouts)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (write_enable) reg_mem[address] = intended_data_in;
    addr_pipe[2] = addr_pipe[1];
    addr_pipe[1] = addr_pipe[0];
    addr_pipe[0] = address;
    readback_data_out = zero_mode ? 12'h000 : reg_mem[addr_pipe[2]];
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [11:0] d);
    req_address[idx*8 +: 8]  = a;
    req_data[idx*12 +: 12]   = d;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic waitWrite(input int budget, output int n);
    n = 0;
    while (n < budget && write_enable !== 1'b1) begin
      tick();
      n++;
    end
  endtask

  task automatic waitResponse(input int budget, output logic [3:0] a,
                              output logic [3:0] e, output int n);
    a = '0;
    e = '0;
    n = 0;
    while (n < budget && a == 4'b0 && e == 4'b0) begin
      tick();
      n++;
      a = ack;
      e = error;
    end
  endtask

  initial begin
    reset       = 1'b1;
    req         = '0;
    req_address = '0;
    req_data    = '0;
    for (int i = 0; i < 256; i++) reg_mem[i] = 12'h000;
    for (int i = 0; i < 3; i++) addr_pipe[i] = 8'h00;
    readback_data_out = 12'h000;

    // ---- reset state ----
    resetDut();
    checkOutput("rst_we",       32'(write_enable),       32'd0);
    checkOutput("rst_busy",     32'(busy),               32'd0);
    checkOutput("rst_ack",      32'(ack),                32'd0);
    checkOutput("rst_error",    32'(error),              32'd0);
    checkOutput("rst_address",  32'(address),            32'd0);
    checkOutput("rst_data",     32'(intended_data_in),   32'd0);
    checkOutput("rst_timeouts", number_of_timeouts,      32'd0);

`ifndef IRSX_ARBITER_VERIFY_EN
    // ---- single request: ack in the third cycle counting the sample cycle ----
    applyStimulus(2, 8'h98, 12'h765);
    req = 4'b0100;
    tick();
    checkOutput("single_we",      32'(write_enable),     32'd1);
    checkOutput("single_address", 32'(address),          32'h98);
    checkOutput("single_data",    32'(intended_data_in), 32'h765);
    checkOutput("single_ack_early", 32'(ack),            32'd0);
    tick();
    checkOutput("single_we_off",  32'(write_enable),     32'd0);
    checkOutput("single_ack",     32'(ack),              32'b0100);
    req = 4'b0000;
    tick();
    checkOutput("single_ack_gone", 32'(ack),             32'd0);
    checkOutput("single_idle",    32'(busy),             32'd0);
    checkOutput("single_hold_addr", 32'(address),        32'h98);
    checkOutput("single_hold_data", 32'(intended_data_in), 32'h765);
`endif

    // ---- fairness: all four held high ----
    resetDut();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'(8'h10 + i), 12'(12'h100 + i));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waitResponse(40, got_ack, got_err, cycles);
      checkOutput($sformatf("fair_grant%0d", g), 32'(got_ack), 32'(4'b0001 << (g % NREQ)));
    end
    req = 4'b0000;
    tick();
    tick();

    // ---- reset during WRITE ----
    resetDut();
    applyStimulus(0, 8'h22, 12'h0aa);
    applyStimulus(1, 8'h11, 12'h0bb);
    req = 4'b0010;
    waitWrite(5, cycles);
    checkOutput("rstw_first_addr", 32'(address), 32'h11);
    reset = 1'b1;
    tick();
    checkOutput("rstw_we",   32'(write_enable), 32'd0);
    checkOutput("rstw_busy", 32'(busy),         32'd0);
    checkOutput("rstw_ack",  32'(ack),          32'd0);
    reset = 1'b0;
    req   = 4'b1111;
    tick();
    checkOutput("rstw_next_we",   32'(write_enable), 32'd1);
    checkOutput("rstw_next_addr", 32'(address),      32'h22);
    waitResponse(40, got_ack, got_err, cycles);
    checkOutput("rstw_next_ack", 32'(got_ack), 32'b0001);
    req = 4'b0000;
    tick();
    tick();

`ifdef IRSX_ARBITER_VERIFY_EN
    // ---- verify: readback matches ----
    resetDut();
    zero_mode = 1'b0;
    applyStimulus(0, 8'h43, 12'h210);
    req = 4'b0001;
    waitWrite(5, cycles);
    checkOutput("vfy_we", 32'(write_enable), 32'd1);
    waitResponse(50, got_ack, got_err, cycles);
    checkOutput("vfy_ack",     32'(got_ack), 32'b0001);
    checkOutput("vfy_err",     32'(got_err), 32'd0);
    checkOutput("vfy_latency", 32'(cycles),  32'(LAT + 2));
    req = 4'b0000;
    tick();

    // ---- verify: requester 1 drops req mid-VERIFY ----
    applyStimulus(1, 8'h5c, 12'habc);
    req = 4'b0010;
    waitWrite(5, cycles);
    tick();
    tick();
    req = 4'b0000;
    waitResponse(50, got_ack, got_err, cycles);
    checkOutput("drop_ack", 32'(got_ack), 32'b0010);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack != 4'b0) extra++;
    end
    checkOutput("drop_ack_once", 32'(extra), 32'd0);

    // ---- verify: readback never matches ----
    zero_mode = 1'b1;
    applyStimulus(3, 8'h0a, 12'h345);
    req = 4'b1000;
    waitWrite(5, cycles);
    waitResponse(TIMEOUT + 20, got_ack, got_err, cycles);
    checkOutput("tmo_err",    32'(got_err), 32'b1000);
    checkOutput("tmo_ack",    32'(got_ack), 32'd0);
    checkOutput("tmo_cycles", 32'(cycles),  32'(TIMEOUT));
    req = 4'b0000;
    tick();
    checkOutput("tmo_count", number_of_timeouts, 32'd1);
    checkOutput("tmo_idle",  32'(busy),          32'd0);
    zero_mode = 1'b0;
`else
    // ---- randomized run against a transaction-level model ----
    resetDut();
    pending   = '0;
    s_cycle   = -100;
    winner    = 0;
    prev      = 0;
    last_rr   = NREQ - 1;
    next_free = 0;
    have_prev = 1'b0;
    exp_addr  = 8'h00;
    exp_data  = 12'h000;
    for (int c = 0; c < 600; c++) begin
      // Grant decision for the upcoming edge.
      if (c >= next_free) begin
        elig = req;
        if (have_prev && c == next_free) elig = elig & ~(4'b0001 << prev);
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          cand = (last_rr + k) % NREQ;
          if (!found && ((elig >> cand) & 4'b0001) != 4'b0000) begin
            found  = 1'b1;
            winner = cand;
          end
        end
        if (found) begin
          s_cycle   = c;
          next_free = c + TXN_CYCLES;
          last_rr   = winner;
          exp_addr  = req_address[winner*8 +: 8];
          exp_data  = req_data[winner*12 +: 12];
        end
      end
      tick();
      exp_ack = (c == s_cycle + 1) ? (4'b0001 << winner) : 4'b0000;
      checkOutput("rnd_we",    32'(write_enable), 32'(c == s_cycle));
      checkOutput("rnd_busy",  32'(busy),         32'(c == s_cycle || c == s_cycle + 1));
      checkOutput("rnd_ack",   32'(ack),          32'(exp_ack));
      checkOutput("rnd_error", 32'(error),        32'd0);
      checkOutput("rnd_addr",  32'(address),      32'(exp_addr));
      checkOutput("rnd_data",  32'(intended_data_in), 32'(exp_data));
      if (c == s_cycle + 1) begin
        pending[winner] = 1'b0;
        have_prev       = 1'b1;
        prev            = winner;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          applyStimulus(i, 8'($urandom_range(0, 255)), 12'($urandom_range(0, 4095)));
        end
      end
      req = pending;
    end
    checkOutput("rnd_timeouts", number_of_timeouts, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/irsx_register_arbiter.md
IRSX_REGISTER_ARBITER -- requirements
Module: irsx_register_arbiter

Interface
REQ-001 SHALL have parameter NUMBER_OF_REQUESTERS, default 4, number of independent register-write requesters.
REQ-002 SHALL have parameter VERIFY_TIMEOUT_CYCLES, default 4096, clock cycles allowed for a readback match.
REQ-003 SHALL have parameter VERIFY_LATENCY, default 3, clock cycles from an address change to valid readback_data_out.
REQ-004 clock  input  1  single clock for all logic.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NUMBER_OF_REQUESTERS  per-requester write request, held high until ack or error.
REQ-007 req_address  input  8*NUMBER_OF_REQUESTERS  register address; requester i uses bits [8i+7:8i].
REQ-008 req_data  input  12*NUMBER_OF_REQUESTERS  register value; requester i uses bits [12i+11:12i].
REQ-009 ack  output  NUMBER_OF_REQUESTERS  one-cycle completion pulse to the granted requester.
REQ-010 error  output  NUMBER_OF_REQUESTERS  one-cycle verify-timeout pulse to the granted requester.
REQ-011 address  output  8  to the register interface address port.
REQ-012 intended_data_in  output  12  to the register interface write-data port.
REQ-013 write_enable  output  1  to the register interface write strobe.
REQ-014 readback_data_out  input  12  from the register interface readback port.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 number_of_timeouts  output  32  count of verify timeouts.

Function
REQ-017 States SHALL be IDLE, WRITE, VERIFY and DONE.
REQ-018 In IDLE, any unmasked req bit SHALL win a round-robin grant: search starts at last_grant+1 and wraps modulo NUMBER_OF_REQUESTERS.
REQ-019 On grant, SHALL latch the index, address and data, drive address and intended_data_in from the latched values, and go to WRITE.
REQ-020 WRITE SHALL last exactly one cycle with write_enable=1; write_enable SHALL be 0 in every other state.
REQ-021 After WRITE, SHALL go to VERIFY if IRSX_ARBITER_VERIFY_EN is defined, otherwise to DONE.
REQ-022 In VERIFY, SHALL hold address, wait VERIFY_LATENCY cycles, then compare readback_data_out with the latched data every cycle.
REQ-023 On a VERIFY match, SHALL go to DONE.
REQ-024 If VERIFY reaches VERIFY_TIMEOUT_CYCLES with no match, SHALL pulse error[grant], increment number_of_timeouts (saturating at 2^32-1), and return to IDLE without ack.
REQ-025 DONE SHALL last one cycle, pulse ack[grant], and return to IDLE.
REQ-026 In the first IDLE cycle after ack or error, the just-served requester's req SHALL be masked.
REQ-027 A req deasserting mid-transaction SHALL NOT abort it; ack/error is still pulsed.
REQ-028 Without the verify option, ack latency SHALL be 3 cycles from req sampled in IDLE: grant edge, WRITE, then DONE.
REQ-029 address and intended_data_in SHALL keep their last values while IDLE.
REQ-030 At most one ack or error bit SHALL be high in any cycle.

Reset
REQ-031 Reset SHALL force state=IDLE, address=0, intended_data_in=0, write_enable=0, ack=0, error=0, busy=0, number_of_timeouts=0, and last_grant=NUMBER_OF_REQUESTERS-1 so requester 0 has first priority.
REQ-032 Reset mid-transaction SHALL abandon it with no ack or error pulse.

Configuration
REQ-033 Macro IRSX_ARBITER_VERIFY_EN SHALL control readback verification.
REQ-034 With IRSX_ARBITER_VERIFY_EN defined, VERIFY and the timeout path SHALL exist.
REQ-035 Without IRSX_ARBITER_VERIFY_EN, VERIFY SHALL be absent, error SHALL be tied to 0, number_of_timeouts SHALL be tied to 0, and readback_data_out SHALL be unused.

Structure
REQ-036 A shared package SHALL hold the state encoding, the ASIC address width (8) and the ASIC data width (12).
REQ-037 The round-robin grant logic SHALL be one sub-module, irsx_round_robin_picker: inputs request vector and last grant; outputs valid and index.

Verification
REQ-038 Single request, verify off: req[2]=1 with addr 0x98 and data 0x765 -> write_enable pulses once with address=0x98 and intended_data_in=0x765, and ack[2] pulses 3 cycles after req is sampled.
REQ-039 Fairness: req=4'b1111 held continuously -> grants occur in order 0,1,2,3,0 with no requester served twice in a row.
REQ-040 Verify on, model returns written data 3 cycles later: write 0x43/0x210 -> ack after VERIFY_LATENCY+1 cycles in VERIFY, and no error.
REQ-041 Verify on, model returns 0x000 for 0x0a/0x345 -> error pulses after exactly VERIFY_TIMEOUT_CYCLES, number_of_timeouts=1, and no ack.
REQ-042 Reset asserted during WRITE -> next cycle write_enable=0, busy=0, no ack, and the next grant goes to requester 0.
REQ-043 Requester 1 drops req mid-VERIFY -> the transaction completes and ack[1] still pulses once.
